node_list_reader: RTL

NODE_LIST_READER -- requirements
Module: node_list_reader

---
 rtl/node_list_reader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/node_list_reader.sv
// Linked-list traversal engine.
// Reads a node's head-table word, then walks the entry RAM one entry at a time.
// Each element is presented on a valid/ready port. A length guard aborts
// traversal of lists that loop back on themselves.
module node_list_reader (
  input  logic        clk,
  input  logic        program_reset,
  input  logic        start_process,
  input  logic [4:0]  node_id,
  output logic        end_process,
  output logic        head_rd,
  output logic [4:0]  head_addr,
  input  logic [7:0]  head_data,
  output logic        entry_rd,
  output logic [6:0]  entry_addr,
  input  logic [15:0] entry_data,
  output logic        elem_valid,
  output logic [7:0]  elem_data,
  input  logic        elem_ready,
  output logic [7:0]  elem_count,
  output logic        loop_error,
  output logic [2:0]  current_state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StReadHead  = 3'd1,
    StWaitHead  = 3'd2,
    StReadEntry = 3'd3,
    StWaitEntry = 3'd4,
    StEmit      = 3'd5,
    StDone      = 3'd6
  } state_e;

  // Longest list accepted before the traversal is treated as cyclic.
  localparam logic [7:0] MaxElems = 8'd128;

  state_e      state_q, state_d;
  logic [4:0]  node_q, node_d;
  logic [6:0]  ptr_q, ptr_d;
  logic [7:0]  data_q, data_d;
  logic        has_next_q, has_next_d;
  logic [6:0]  next_ptr_q, next_ptr_d;
  logic [7:0]  count_q, count_d;
  logic        loop_err_q, loop_err_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (program_reset) begin
      state_q    <= StIdle;
      node_q     <= 5'd0;
      ptr_q      <= 7'd0;
      data_q     <= 8'd0;
      has_next_q <= 1'b0;
      next_ptr_q <= 7'd0;
      count_q    <= 8'd0;
      loop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      node_q     <= node_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      has_next_q <= has_next_d;
      next_ptr_q <= next_ptr_d;
      count_q    <= count_d;
      loop_err_q <= loop_err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    has_next_d = has_next_q;
    next_ptr_d = next_ptr_q;
    count_d    = count_q;
    loop_err_d = loop_err_q;
    case (state_q)
      StIdle: begin
        if (start_process) begin
          node_d     = node_id;
          count_d    = 8'd0;
          loop_err_d = 1'b0;
          state_d    = StReadHead;
        end
      end
      StReadHead:  state_d = StWaitHead;
      StWaitHead: begin
        if (!head_data[7]) begin
          state_d = StDone;
        end else begin
          ptr_d   = head_data[6:0];
          state_d = StReadEntry;
        end
      end
      StReadEntry: state_d = StWaitEntry;
      StWaitEntry: begin
        data_d     = entry_data[7:0];
        has_next_d = entry_data[15];
        next_ptr_d = entry_data[14:8];
        state_d    = StEmit;
      end
      StEmit: begin
        if (elem_ready) begin
          count_d = count_q + 8'd1;
          if (!has_next_q) begin
            state_d = StDone;
          end else if (count_d == MaxElems) begin
            loop_err_d = 1'b1;
            state_d    = StDone;
          end else begin
            ptr_d   = next_ptr_q;
            state_d = StReadEntry;
          end
        end
      end
      StDone: begin
        if (!start_process) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes and flags decode from the current state only.
  always_comb begin
    head_rd     = (state_q == StReadHead);
    entry_rd    = (state_q == StReadEntry);
    elem_valid  = (state_q == StEmit);
    end_process = (state_q == StDone);
  end

  assign head_addr     = node_q;
  assign entry_addr    = ptr_q;
  assign elem_data     = data_q;
  assign elem_count    = count_q;
  assign loop_error    = loop_err_q;
  assign current_state = state_q;

endmodule
